sdram_port_arbiter: RTL

Shares the single SDRAM port between the core's three memory requesters: instruction-cache line fill, data-cache line fill and data-cache write-back. It sits between `mips_core` and the SDRAM model or controller. It grants one line-sized transaction at a time and steers the address, write data and returned read data. Ordering is by grant, so a write-back that is granted first always completes before any later read of the same line is issued.

---
 rtl/sdram_port_arbiter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// -----------------------------------------------------------------------------
// Shares the single SDRAM port between three line-sized requesters: I-cache
// line fill (read), D-cache line fill (read) and D-cache write-back (write).
// Only one transaction is in flight at a time. Transactions are issued in
// grant order, so a write-back granted first completes before any later read
// of the same line is issued.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_rd_addr*/i_rd_data*          I-cache read request / returned data
//   d_rd_addr*/d_rd_data*          D-cache read request / returned data
//   d_wr_addr*/d_wr_data*          D-cache write-back address / data beats
//   m_rd_addr*/m_rd_data*          memory read address / returned data
//   m_wr_addr*/m_wr_data*          memory write address / data beats
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int AW         = 26,
  parameter int DW         = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_rd_addr,
  input  logic          i_rd_addr_valid,
  output logic          i_rd_addr_ready,
  output logic [DW-1:0] i_rd_data,
  output logic          i_rd_data_valid,
  input  logic [AW-1:0] d_rd_addr,
  input  logic          d_rd_addr_valid,
  output logic          d_rd_addr_ready,
  output logic [DW-1:0] d_rd_data,
  output logic          d_rd_data_valid,
  input  logic [AW-1:0] d_wr_addr,
  input  logic          d_wr_addr_valid,
  output logic          d_wr_addr_ready,
  input  logic [DW-1:0] d_wr_data,
  input  logic          d_wr_data_valid,
  output logic          d_wr_data_ready,
  output logic [AW-1:0] m_rd_addr,
  output logic          m_rd_addr_valid,
  input  logic          m_rd_addr_ready,
  input  logic [DW-1:0] m_rd_data,
  input  logic          m_rd_data_valid,
  output logic [AW-1:0] m_wr_addr,
  output logic          m_wr_addr_valid,
  input  logic          m_wr_addr_ready,
  output logic [DW-1:0] m_wr_data,
  output logic          m_wr_data_valid,
  input  logic          m_wr_data_ready
);

  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_DATA = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I_RD = 2'd1,
    GNT_D_RD = 2'd2,
    GNT_D_WR = 2'd3
  } grant_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_d_q, last_d_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          own_dcache_q, own_dcache_d;  // 1: D-cache owns the current read

  grant_e        grant_s;
  logic          rd_beat_s;
  logic          wr_beat_s;

  // Grant decision, only evaluated while idle. The I-cache jumps the queue
  // when the previous grant went to the D-cache so it cannot be starved.
  always_comb begin
    grant_s = GNT_NONE;
    if (state_q == ST_IDLE) begin
      if (i_rd_addr_valid && last_d_q) begin
        grant_s = GNT_I_RD;
      end else if (d_wr_addr_valid) begin
        grant_s = GNT_D_WR;
      end else if (d_rd_addr_valid) begin
        grant_s = GNT_D_RD;
      end else if (i_rd_addr_valid) begin
        grant_s = GNT_I_RD;
      end else begin
        grant_s = GNT_NONE;
      end
    end else begin
      grant_s = GNT_NONE;
    end
  end

  // Data beats that advance the line counter.
  always_comb begin
    rd_beat_s = (state_q == ST_RD_DATA) && m_rd_data_valid;
    wr_beat_s = (state_q == ST_WR_DATA) && d_wr_data_valid && m_wr_data_ready;
  end

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d_d     = last_d_q;
    addr_d       = addr_q;
    own_dcache_d = own_dcache_q;
    case (state_q)
      ST_IDLE: begin
        case (grant_s)
          GNT_I_RD: begin
            state_d      = ST_RD_ADDR;
            addr_d       = i_rd_addr;
            own_dcache_d = 1'b0;
            last_d_d     = 1'b0;
          end
          GNT_D_RD: begin
            state_d      = ST_RD_ADDR;
            addr_d       = d_rd_addr;
            own_dcache_d = 1'b1;
            last_d_d     = 1'b1;
          end
          GNT_D_WR: begin
            state_d  = ST_WR_ADDR;
            addr_d   = d_wr_addr;
            last_d_d = 1'b1;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
      ST_RD_ADDR: begin
        if (m_rd_addr_ready) begin
          state_d = ST_RD_DATA;
        end else begin
          state_d = ST_RD_ADDR;
        end
      end
      ST_RD_DATA: begin
        if (rd_beat_s) begin
          // Counter width matches the line, so the last beat wraps it to 0.
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RD_DATA;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_WR_ADDR: begin
        if (m_wr_addr_ready) begin
          state_d = ST_WR_DATA;
        end else begin
          state_d = ST_WR_ADDR;
        end
      end
      ST_WR_DATA: begin
        if (wr_beat_s) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WR_DATA;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Sequencer state, beat counter, fairness bit and captured address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CW{1'b0}};
      last_d_q     <= 1'b0;
      addr_q       <= {AW{1'b0}};
      own_dcache_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_d_q     <= last_d_d;
      addr_q       <= addr_d;
      own_dcache_q <= own_dcache_d;
    end
  end

  // Output steering: every handshake is qualified by the owning state so a
  // requester without the grant never sees ready or valid.
  always_comb begin
    i_rd_addr_ready = (grant_s == GNT_I_RD);
    d_rd_addr_ready = (grant_s == GNT_D_RD);
    d_wr_addr_ready = (grant_s == GNT_D_WR);

    m_rd_addr       = addr_q;
    m_rd_addr_valid = (state_q == ST_RD_ADDR);
    m_wr_addr       = addr_q;
    m_wr_addr_valid = (state_q == ST_WR_ADDR);

    // Read data goes to both requesters; only the valid is steered.
    if (state_q == ST_RD_DATA) begin
      i_rd_data = m_rd_data;
      d_rd_data = m_rd_data;
    end else begin
      i_rd_data = {DW{1'b0}};
      d_rd_data = {DW{1'b0}};
    end
    i_rd_data_valid = rd_beat_s && !own_dcache_q;
    d_rd_data_valid = rd_beat_s && own_dcache_q;

    if (state_q == ST_WR_DATA) begin
      m_wr_data       = d_wr_data;
      m_wr_data_valid = d_wr_data_valid;
      d_wr_data_ready = m_wr_data_ready;
    end else begin
      m_wr_data       = {DW{1'b0}};
      m_wr_data_valid = 1'b0;
      d_wr_data_ready = 1'b0;
    end
  end

endmodule
